// File: rtl/cube_pkg.sv
// Shared constants and state types for the 8x8x8 LED cube scan driver.
package cube_pkg;

    localparam int CUBE_LAYERS = 8;
    localparam int LAYER_BITS  = 64;
    localparam int FRAME_BITS  = 512;
    localparam int LAYER_IDX_W = $clog2(CUBE_LAYERS);
    localparam int LAYER_SH_W  = $clog2(LAYER_BITS);

    localparam logic [LAYER_IDX_W-1:0] LAST_LAYER = LAYER_IDX_W'(CUBE_LAYERS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_LATCH,
        ST_DWELL
    } scan_state_e;

    typedef enum logic [1:0] {
        SH_IDLE,
        SH_SHIFT,
        SH_LATCH
    } shift_state_e;

    function automatic logic [CUBE_LAYERS-1:0] layer_onehot(input logic [LAYER_IDX_W-1:0] l);
        logic [CUBE_LAYERS-1:0] oh;
        oh    = '0;
        oh[l] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/hc595_shifter.sv
// Serialises one 64-bit layer MSB first into a 74HC595 chain, then pulses the storage latch.
module hc595_shifter
    import cube_pkg::*;
#(
    parameter int CLK_DIV = 4
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  abort,
    input  logic                  start,
    input  logic [LAYER_BITS-1:0] data,
    output logic                  busy,
    output logic                  shift_end,
    output logic                  done,
    output logic                  ser,
    output logic                  srclk,
    output logic                  rclk
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CYC_LAST = CW'(CLK_DIV - 1);
    localparam logic [LAYER_SH_W-1:0] BIT_LAST = LAYER_SH_W'(LAYER_BITS - 1);

    shift_state_e            st_q, st_d;
    logic [CW-1:0]           cyc_q, cyc_d;
    logic [LAYER_SH_W-1:0]   bit_q, bit_d;
    logic [LAYER_BITS-1:0]   sreg_q, sreg_d;
    logic                    ser_q, ser_d;
    logic                    srclk_q, srclk_d;
    logic                    rclk_q, rclk_d;
    logic                    cyc_last;

    assign cyc_last = (cyc_q == CYC_LAST);

    always_comb begin
        st_d      = st_q;
        cyc_d     = cyc_q;
        bit_d     = bit_q;
        sreg_d    = sreg_q;
        ser_d     = ser_q;
        srclk_d   = srclk_q;
        rclk_d    = rclk_q;
        shift_end = 1'b0;
        done      = 1'b0;
        if (abort) begin
            st_d    = SH_IDLE;
            cyc_d   = '0;
            bit_d   = '0;
            ser_d   = 1'b0;
            srclk_d = 1'b0;
            rclk_d  = 1'b0;
        end else begin
            case (st_q)
                SH_IDLE: begin
                    if (start) begin
                        st_d    = SH_SHIFT;
                        sreg_d  = data;
                        ser_d   = data[LAYER_BITS-1];
                        srclk_d = 1'b0;
                        cyc_d   = '0;
                        bit_d   = '0;
                    end
                end
                SH_SHIFT: begin
                    if (!cyc_last) begin
                        cyc_d = cyc_q + 1'b1;
                    end else begin
                        cyc_d = '0;
                        if (!srclk_q) begin
                            srclk_d = 1'b1;
                        end else if (bit_q == BIT_LAST) begin
                            // Last bit clocked in: go straight into the latch pulse.
                            shift_end = 1'b1;
                            st_d      = SH_LATCH;
                            srclk_d   = 1'b0;
                            rclk_d    = 1'b1;
                            ser_d     = 1'b0;
                        end else begin
                            sreg_d  = {sreg_q[LAYER_BITS-2:0], 1'b0};
                            ser_d   = sreg_q[LAYER_BITS-2];
                            srclk_d = 1'b0;
                            bit_d   = bit_q + 1'b1;
                        end
                    end
                end
                SH_LATCH: begin
                    if (!cyc_last) begin
                        cyc_d = cyc_q + 1'b1;
                    end else begin
                        cyc_d  = '0;
                        rclk_d = 1'b0;
                        done   = 1'b1;
                        st_d   = SH_IDLE;
                    end
                end
                default: st_d = SH_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            st_q    <= SH_IDLE;
            cyc_q   <= '0;
            bit_q   <= '0;
            sreg_q  <= '0;
            ser_q   <= 1'b0;
            srclk_q <= 1'b0;
            rclk_q  <= 1'b0;
        end else begin
            st_q    <= st_d;
            cyc_q   <= cyc_d;
            bit_q   <= bit_d;
            sreg_q  <= sreg_d;
            ser_q   <= ser_d;
            srclk_q <= srclk_d;
            rclk_q  <= rclk_d;
        end
    end

    assign busy  = (st_q != SH_IDLE);
    assign ser   = ser_q;
    assign srclk = srclk_q;
    assign rclk  = rclk_q;

endmodule

// File: rtl/cube_scan_driver.sv
// Double-buffered layer scanner for an 8x8x8 LED cube driven through a 74HC595 chain.
module cube_scan_driver
    import cube_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int DWELL   = 10000
)
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [FRAME_BITS-1:0]  frame_cube_flat,
    input  logic                   frame_valid,
    output logic                   ser,
    output logic                   srclk,
    output logic                   rclk,
    output logic [CUBE_LAYERS-1:0] layer_sel,
    output logic                   frame_done
);

    localparam int DCW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DCW-1:0] DWELL_LAST = DCW'(DWELL - 1);

    scan_state_e                 state_q, state_d;
    logic [LAYER_IDX_W-1:0]      layer_q, layer_d;
    logic [DCW-1:0]              dwell_q, dwell_d;
    logic [CUBE_LAYERS-1:0]      layer_sel_q, layer_sel_d;
    logic                        frame_done_q, frame_done_d;
    logic                        pending_q, pending_d;
    logic [FRAME_BITS-1:0]       shadow_q, shadow_d;
    logic [FRAME_BITS-1:0]       active_q, active_d;

    logic                        swap;
    logic                        sh_start;
    logic                        sh_busy;
    logic                        sh_shift_end;
    logic                        sh_done;
    logic [FRAME_BITS-1:0]       scan_src;
    logic [LAYER_IDX_W+LAYER_SH_W-1:0] layer_base;
    logic [LAYER_BITS-1:0]       sh_data;

    always_comb begin
        state_d      = state_q;
        layer_d      = layer_q;
        dwell_d      = dwell_q;
        layer_sel_d  = layer_sel_q;
        frame_done_d = 1'b0;
        swap         = 1'b0;
        sh_start     = 1'b0;
        if (!en) begin
            state_d     = ST_IDLE;
            layer_d     = '0;
            dwell_d     = '0;
            layer_sel_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    layer_sel_d = '0;
                    if (!sh_busy) begin
                        state_d  = ST_SHIFT;
                        layer_d  = '0;
                        sh_start = 1'b1;
                    end
                end
                // The previous layer stays lit while the next one shifts in.
                ST_SHIFT: begin
                    if (sh_shift_end) begin
                        state_d     = ST_LATCH;
                        layer_sel_d = '0;
                    end
                end
                ST_LATCH: begin
                    if (sh_done) begin
                        state_d     = ST_DWELL;
                        dwell_d     = '0;
                        layer_sel_d = layer_onehot(layer_q);
                    end
                end
                ST_DWELL: begin
                    if (dwell_q == DWELL_LAST) begin
                        state_d  = ST_SHIFT;
                        dwell_d  = '0;
                        layer_d  = layer_q + 1'b1;
                        sh_start = 1'b1;
                        if (layer_q == LAST_LAYER && pending_q) begin
                            swap         = 1'b1;
                            frame_done_d = 1'b1;
                        end
                    end else begin
                        dwell_d = dwell_q + 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // A frame arriving on the swap edge lands in shadow and stays pending.
        pending_d = frame_valid | (pending_q & ~swap);
        shadow_d  = frame_valid ? frame_cube_flat : shadow_q;
        active_d  = swap ? shadow_q : active_q;

        scan_src   = swap ? shadow_q : active_q;
        layer_base = {layer_d, {LAYER_SH_W{1'b0}}};
        sh_data    = scan_src[layer_base +: LAYER_BITS];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            layer_q      <= '0;
            dwell_q      <= '0;
            layer_sel_q  <= '0;
            frame_done_q <= 1'b0;
            pending_q    <= 1'b0;
            shadow_q     <= '0;
            active_q     <= '0;
        end else begin
            state_q      <= state_d;
            layer_q      <= layer_d;
            dwell_q      <= dwell_d;
            layer_sel_q  <= layer_sel_d;
            frame_done_q <= frame_done_d;
            pending_q    <= pending_d;
            shadow_q     <= shadow_d;
            active_q     <= active_d;
        end
    end

    hc595_shifter #(
        .CLK_DIV (CLK_DIV)
    ) u_shifter (
        .clk       (clk),
        .rst       (rst),
        .abort     (~en),
        .start     (sh_start),
        .data      (sh_data),
        .busy      (sh_busy),
        .shift_end (sh_shift_end),
        .done      (sh_done),
        .ser       (ser),
        .srclk     (srclk),
        .rclk      (rclk)
    );

    assign layer_sel  = layer_sel_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_cube_scan_driver.sv
// Bench for cube_scan_driver (CLK_DIV=1, DWELL=8): random frames against a frame-level buffer model.
module tb_cube_scan_driver;

    localparam int CLK_DIV   = 1;
    localparam int DWELL     = 8;
    localparam int SHIFT_CYC = 128 * CLK_DIV;
    localparam int LAYER_CYC = SHIFT_CYC + CLK_DIV + DWELL;
    localparam int SCAN_CYC  = 8 * LAYER_CYC;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic [511:0] frame_cube_flat;
    logic         frame_valid;
    logic         ser;
    logic         srclk;
    logic         rclk;
    logic [7:0]   layer_sel;
    logic         frame_done;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [511:0] m_shadow  = '0;
    logic [511:0] m_active  = '0;
    bit           m_pending = 1'b0;
    logic [511:0] next_frame;
    int           fv_sched[$];
    logic [7:0]   g_prev;
    bit           g_fd;

    cube_scan_driver #(
        .CLK_DIV (CLK_DIV),
        .DWELL   (DWELL)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .en              (en),
        .frame_cube_flat (frame_cube_flat),
        .frame_valid     (frame_valid),
        .ser             (ser),
        .srclk           (srclk),
        .rclk            (rclk),
        .layer_sel       (layer_sel),
        .frame_done      (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [511:0] rand_frame();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom();
        return r;
    endfunction

    // One clock edge: apply any scheduled frame, update the buffer model, move to the next negedge.
    task automatic step(input bit swap_here, output bit did_swap);
        bit do_fv;
        do_fv    = 1'b0;
        did_swap = 1'b0;
        if (fv_sched.size() > 0 && fv_sched[0] <= cyc) begin
            void'(fv_sched.pop_front());
            do_fv           = 1'b1;
            frame_cube_flat = next_frame;
            frame_valid     = 1'b1;
            next_frame      = rand_frame();
        end
        if (!rst) begin
            m_shadow  = '0;
            m_active  = '0;
            m_pending = 1'b0;
        end else begin
            if (swap_here && en && m_pending) begin
                m_active  = m_shadow;
                m_pending = 1'b0;
                did_swap  = 1'b1;
            end
            if (do_fv) begin
                m_shadow  = frame_cube_flat;
                m_pending = 1'b1;
            end
        end
        @(negedge clk);
        frame_valid = 1'b0;
        cyc++;
    endtask

    task automatic steps(input int n);
        bit d;
        for (int i = 0; i < n; i++) step(1'b0, d);
    endtask

    task automatic scan_layer(input int l);
        logic [63:0] cap;
        logic [63:0] exp_word;
        logic [7:0]  oh;
        logic        ser_low;
        int          bad;
        bit          d;
        cap      = '0;
        bad      = 0;
        ser_low  = 1'b0;
        oh       = 8'h01 << l;
        exp_word = m_active[64*l +: 64];
        check($sformatf("frame_done_L%0d", l), 64'(frame_done), 64'(g_fd));
        for (int k = 0; k < SHIFT_CYC; k++) begin
            if (srclk !== k[0] || rclk !== 1'b0 || layer_sel !== g_prev) bad++;
            if (k > 0 && frame_done !== 1'b0) bad++;
            if (k[0] == 1'b0) ser_low = ser;
            else begin
                if (ser !== ser_low) bad++;
                cap = {cap[62:0], ser};
            end
            step(1'b0, d);
        end
        check($sformatf("shift_data_L%0d", l), cap, exp_word);
        check($sformatf("shift_timing_L%0d", l), 64'(bad), 64'd0);
        check($sformatf("latch_L%0d", l), {52'd0, rclk, srclk, frame_done, 1'b0, layer_sel},
              {52'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
        step(1'b0, d);
        bad = 0;
        for (int k = 0; k < DWELL; k++) begin
            if (layer_sel !== oh || rclk !== 1'b0 || srclk !== 1'b0 || frame_done !== 1'b0) bad++;
            step((k == DWELL - 1) && (l == 7), d);
        end
        check($sformatf("dwell_L%0d", l), 64'(bad), 64'd0);
        g_prev = oh;
        g_fd   = d;
    endtask

    task automatic run_scan();
        for (int l = 0; l < 8; l++) scan_layer(l);
    endtask

    initial begin
        int c0;
        int n;
        rst             = 1'b0;
        en              = 1'b0;
        frame_valid     = 1'b0;
        frame_cube_flat = '0;
        next_frame      = rand_frame();
        g_prev          = 8'h00;
        g_fd            = 1'b0;
        @(negedge clk);
        steps(2);
        check("reset_outputs", {51'd0, ser, srclk, rclk, frame_done, layer_sel}, 64'd0);

        // Blank cube after reset: all-zero data shifted out, layers walk 0..7.
        rst = 1'b1;
        en  = 1'b1;
        steps(1);
        run_scan();

        // Single frame with a known layer 0 pattern, picked up at the next scan boundary.
        next_frame        = rand_frame();
        next_frame[63:0]  = 64'hA5A5_0000_0000_00FF;
        fv_sched.push_back(cyc + 50);
        run_scan();
        run_scan();
        check("pattern_l0_active", m_active[63:0], 64'hA5A5_0000_0000_00FF);

        // Two frames in one scan: only the later one is shown.
        c0 = cyc;
        fv_sched.push_back(c0 + $urandom_range(5, 400));
        fv_sched.push_back(c0 + $urandom_range(500, 1000));
        run_scan();
        run_scan();

        // First frame mid-scan, second exactly on the swap edge.
        c0 = cyc;
        fv_sched.push_back(c0 + 200);
        fv_sched.push_back(c0 + SCAN_CYC - 1);
        run_scan();
        run_scan();
        run_scan();

        // Random frame arrivals.
        for (int s = 0; s < 2; s++) begin
            c0 = cyc;
            n  = $urandom_range(0, 3);
            for (int j = 0; j < n; j++) fv_sched.push_back(c0 + 100 + j * 300 + $urandom_range(0, 250));
            run_scan();
        end

        // Drop enable in the middle of shifting layer 3, then resume from layer 0.
        fv_sched.push_back(cyc + 30);
        for (int l = 0; l < 3; l++) scan_layer(l);
        steps($urandom_range(5, 120));
        en = 1'b0;
        steps(1);
        check("en_drop_outputs", {53'd0, srclk, rclk, layer_sel}, 64'd0);
        steps(3);
        check("en_low_idle", {53'd0, srclk, rclk, layer_sel}, 64'd0);
        en = 1'b1;
        steps(1);
        g_prev = 8'h00;
        g_fd   = 1'b0;
        run_scan();
        run_scan();

        // Reset during layer 5 dwell, with a frame offered while reset is held.
        for (int l = 0; l < 5; l++) scan_layer(l);
        steps(SHIFT_CYC + CLK_DIV + 3);
        rst = 1'b0;
        steps(1);
        check("rst_mid_dwell_outputs", {51'd0, ser, srclk, rclk, frame_done, layer_sel}, 64'd0);
        fv_sched.push_back(cyc);
        steps(1);
        check("rst_held_outputs", {51'd0, ser, srclk, rclk, frame_done, layer_sel}, 64'd0);
        rst = 1'b1;
        steps(1);
        g_prev = 8'h00;
        g_fd   = 1'b0;
        run_scan();
        check("post_reset_no_swap", 64'(frame_done), 64'(g_fd));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cube_scan_driver.md
CUBE_SCAN_DRIVER -- requirements
Module: cube_scan_driver

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, clk cycles per srclk half-period (>=1).
REQ-002 SHALL have parameter DWELL, default 10000, clk cycles each layer is lit (>=1).
REQ-003 SHALL have port clk  input  1  system clock (100 MHz).
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port en  input  1  scan enable; low blanks the cube.
REQ-006 SHALL have port frame_cube_flat  input  512  frame; byte i = bits [8i+7:8i]; layer L = bits [64L+63:64L].
REQ-007 SHALL have port frame_valid  input  1  one-cycle pulse; frame_cube_flat is valid that cycle.
REQ-008 SHALL have port ser  output  1  serial data to the 74HC595 chain.
REQ-009 SHALL have port srclk  output  1  shift clock; chain samples ser on rising edge.
REQ-010 SHALL have port rclk  output  1  storage latch clock.
REQ-011 SHALL have port layer_sel  output  8  one-hot layer enable, bit L = layer L.
REQ-012 SHALL have port frame_done  output  1  one-cycle pulse when a new frame becomes active.

Function
REQ-013 SHALL hold two 512-bit buffers: shadow (written on frame_valid) and active (scanned); a pending flag marks an unswapped shadow.
REQ-014 On frame_valid, SHALL copy frame_cube_flat into shadow next edge and set pending; a later frame_valid before swap overwrites shadow (latest wins).
REQ-015 FSM states: IDLE, SHIFT, LATCH, DWELL; layer counter L, 3 bits.
REQ-016 IDLE: layer_sel=0, srclk=0, rclk=0; leaves to SHIFT with L=0 when en=1.
REQ-017 SHIFT: sends 64 bits of active layer L, bit 64L+63 first; per bit ser set with srclk=0 for CLK_DIV cycles, then srclk=1 for CLK_DIV cycles; 128*CLK_DIV cycles total; previous layer_sel unchanged.
REQ-018 LATCH: layer_sel=0, rclk=1 for CLK_DIV cycles, then DWELL.
REQ-019 DWELL: layer_sel = one-hot of L for exactly DWELL cycles; then L increments (7 wraps to 0) and FSM enters SHIFT.
REQ-020 On the DWELL->SHIFT transition with L=7 and pending=1, SHALL copy shadow to active, clear pending, pulse frame_done one cycle; the next layer 0 is from the new frame (no tearing within a scan).
REQ-021 If frame_valid coincides with a swap, swap uses old shadow, the new frame is written to shadow, and pending remains 1.
REQ-022 en=0 in any state SHALL return FSM to IDLE next cycle with layer_sel=0, srclk=0, rclk=0; buffers and pending kept.
REQ-023 Counters SHALL be sized from parameters; no overflow at DWELL or 128*CLK_DIV maxima.

Reset
REQ-024 While rst=0: state IDLE, L=0, ser/srclk/rclk/layer_sel/frame_done=0, pending=0, both buffers zero.
REQ-025 Reset mid-SHIFT/DWELL SHALL abort immediately with no further srclk/rclk edges; a frame_valid during reset is dropped.

Structure
REQ-026 Shared package cube_pkg SHALL hold CUBE_LAYERS=8, LAYER_BITS=64, FRAME_BITS=512 and the FSM state type.
REQ-027 The serial shift/latch timing SHALL be one sub-module hc595_shifter (start, 64-bit data, busy/done, ser/srclk/rclk); the top keeps buffers, layer counter and dwell timer.

Verification (CLK_DIV=1, DWELL=8)
REQ-028 Reset, en=1, no frame -> 64 srclk rising edges with ser=0, one rclk pulse, layer_sel=8'h01 for 8 cycles, then 8'h02.
REQ-029 frame_valid with layer 0 = 64'hA5A5_0000_0000_00FF -> after current scan completes, frame_done pulse; layer 0 shift sequence A5A5...00FF MSB first captured on srclk edges.
REQ-030 Two frame_valid pulses (frames X, Y) within one scan -> single frame_done; Y displayed, X never.
REQ-031 frame_valid on the same cycle as a swap -> frame_done, old shadow active, new frame active after next full scan with second frame_done.
REQ-032 en dropped mid-SHIFT of layer 3 -> layer_sel=0, srclk/rclk=0 next cycle; en raised -> restart at layer 0, frame unchanged.
REQ-033 rst=0 during DWELL of layer 5 -> all outputs 0 next cycle, active buffer zeroed, pending cleared.
